multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clock  in  1  rising-edge system clock.
REQ-002 reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
REQ-003 opcode  in  7  instruction opcode from IR, instr[6:0].
REQ-004 funct3  in  3  instr[14:12].
REQ-005 funct7  in  1  instr[30]; 1 selects SUB for R-type.
REQ-006 alu_flags  in  3  [0] zero, [1] MSB of result, [2] signed overflow; all from the current ALU result.
REQ-007 weIR, wePC, weReg, weMem  out  1 each  write enables for IR, PC, register file and data memory.
REQ-008 sinalMux1  out  1  ALU operand B: 0 = imm, 1 = doutB.
REQ-009 sinalMux2  out  2  register write data: 00 = memory, 01 = ALU, 10 = PC+4, 11 = PC+imm.
REQ-010 sinalMux4  out  1  target adder base: 0 = PC, 1 = doutA.
REQ-011 pc_src  out  1  next PC: 0 = PC+4, 1 = target adder.
REQ-012 control  out  4  ALU command: 0010 = ADD, 0110 = SUB.
REQ-013 state_reg  out  4  current state code.
REQ-014 halted  out  1  high while in HALT.
REQ-015 retired  out  32  count of completed instructions.

Function
REQ-016 Moore FSM; outputs decode state_reg only, except pc_src in BRANCH, which also uses alu_flags.
REQ-017 State codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB_ALU=4, MEM_ADDR=5, MEM_READ=6, MEM_WB=7, MEM_WRITE=8, BRANCH=9, JAL=10, JALR=11, AUIPC=12, HALT=15; codes 13 and 14 go to HALT.
REQ-018 FETCH: weIR=1; next state DECODE.
REQ-019 DECODE next state by opcode:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0000011 or 0100011 -> MEM_ADDR
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0010111 -> AUIPC
- any other opcode -> HALT
REQ-020 EXEC_R: sinalMux1=1; control=0110 if funct7=1, else 0010; next WB_ALU.
REQ-021 EXEC_I: sinalMux1=0, control=0010; next WB_ALU.
REQ-022 WB_ALU: weReg=1, sinalMux2=01, wePC=1, pc_src=0; next FETCH.
REQ-023 MEM_ADDR: sinalMux1=0, control=0010; next MEM_READ for opcode 0000011, otherwise MEM_WRITE.
REQ-024 MEM_READ: holds the MEM_ADDR ALU controls; next MEM_WB.
REQ-025 MEM_WB: holds the address controls; weReg=1, sinalMux2=00, wePC=1, pc_src=0; next FETCH.
REQ-026 MEM_WRITE: holds the address controls; weMem=1 for exactly one cycle, wePC=1, pc_src=0; next FETCH.
REQ-027 BRANCH: sinalMux1=1, control=0110, sinalMux4=0, wePC=1; pc_src by funct3:
- 000: zero
- 001: !zero
- 100: MSB^overflow
- 101: !(MSB^overflow)
- next state FETCH.
REQ-028 BRANCH with funct3 of 010, 011, 110 or 111: no enables asserted; next HALT.
REQ-029 JAL: weReg=1, sinalMux2=10, sinalMux4=0, pc_src=1, wePC=1; next FETCH.
REQ-030 JALR: as JAL, but sinalMux4=1.
REQ-031 AUIPC: weReg=1, sinalMux2=11, sinalMux4=0, wePC=1, pc_src=0; next FETCH.
REQ-032 HALT: all enables 0, halted=1; stays in HALT until reset.
REQ-033 Unlisted outputs in any state are 0; control defaults to 0010.
REQ-034 retired increments by 1 on each rising clock edge where wePC=1; wraps from 0xFFFFFFFF to 0.
REQ-035 Cycles per instruction: R/I/store = 4, load = 5, branch/JAL/JALR/AUIPC = 3.

Reset
REQ-036 While reset is high: state_reg=0 (FETCH), retired=0, all write enables forced to 0, halted=0, pc_src=0, sinalMux*=0, control=0010.
REQ-037 Reset asserted mid-instruction aborts it immediately; no enable pulses during reset.
REQ-038 After release, the first rising edge executes FETCH.

Verification
REQ-039 Release reset, opcode=0110011, funct7=1 -> states 0,1,2,4,0; control=0110 in EXEC_R; one weReg pulse; retired=1.
REQ-040 Load (0000011) -> states 0,1,5,6,7,0; sinalMux2=00 in MEM_WB; weMem never 1. Store (0100011) -> weMem high exactly 1 cycle in state 8.
REQ-041 BRANCH with funct3=000: zero=1 -> pc_src=1; zero=0 -> pc_src=0. funct3=100 with MSB=1, overflow=1 -> pc_src=0.
REQ-042 JALR -> sinalMux4=1, sinalMux2=10, pc_src=1, weReg=1 in state 11.
REQ-043 opcode=1111111 -> HALT (15), halted=1, retired frozen; assert reset -> state 0, retired=0.
REQ-044 Assert reset during MEM_WRITE -> weMem drops to 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore FSM driving datapath enables and muxes,
// plus a 32-bit retired-instruction counter.
module multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [2:0]  alu_flags,
  output logic        weIR,
  output logic        wePC,
  output logic        weReg,
  output logic        weMem,
  output logic        sinalMux1,
  output logic [1:0]  sinalMux2,
  output logic        sinalMux4,
  output logic        pc_src,
  output logic [3:0]  control,
  output logic [3:0]  state_reg,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    WB_ALU    = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR      = 4'd11,
    AUIPC     = 4'd12,
    HALT      = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t state;
  state_t next_state;

  logic flag_zero;
  logic signed_lt;
  logic branch_ok;

  assign flag_zero = alu_flags[0];
  assign signed_lt = alu_flags[1] ^ alu_flags[2];
  assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
  assign state_reg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = HALT;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          7'b0110011: next_state = EXEC_R;
          7'b0010011: next_state = EXEC_I;
          7'b0000011,
          7'b0100011: next_state = MEM_ADDR;
          7'b1100011: next_state = BRANCH;
          7'b1101111: next_state = JAL;
          7'b1100111: next_state = JALR;
          7'b0010111: next_state = AUIPC;
          default:    next_state = HALT;
        endcase
      end
      EXEC_R, EXEC_I: next_state = WB_ALU;
      WB_ALU:         next_state = FETCH;
      MEM_ADDR:       next_state = (opcode == 7'b0000011) ? MEM_READ : MEM_WRITE;
      MEM_READ:       next_state = MEM_WB;
      MEM_WB:         next_state = FETCH;
      MEM_WRITE:      next_state = FETCH;
      BRANCH:         next_state = branch_ok ? FETCH : HALT;
      JAL, JALR:      next_state = FETCH;
      AUIPC:          next_state = FETCH;
      default:        next_state = HALT;
    endcase
  end

  // Reset overrides the state decode combinationally so enables drop without a clock edge.
  always_comb begin
    weIR      = 1'b0;
    wePC      = 1'b0;
    weReg     = 1'b0;
    weMem     = 1'b0;
    sinalMux1 = 1'b0;
    sinalMux2 = 2'b00;
    sinalMux4 = 1'b0;
    pc_src    = 1'b0;
    control   = ALU_ADD;
    halted    = 1'b0;
    case (state)
      FETCH:  weIR = 1'b1;
      EXEC_R: begin
        sinalMux1 = 1'b1;
        control   = funct7 ? ALU_SUB : ALU_ADD;
      end
      EXEC_I: control = ALU_ADD;
      WB_ALU: begin
        weReg     = 1'b1;
        sinalMux2 = 2'b01;
        wePC      = 1'b1;
      end
      MEM_ADDR, MEM_READ: control = ALU_ADD;
      MEM_WB: begin
        weReg = 1'b1;
        wePC  = 1'b1;
      end
      MEM_WRITE: begin
        weMem = 1'b1;
        wePC  = 1'b1;
      end
      BRANCH: begin
        sinalMux1 = 1'b1;
        control   = ALU_SUB;
        if (branch_ok) begin
          wePC = 1'b1;
          case (funct3)
            3'b000:  pc_src = flag_zero;
            3'b001:  pc_src = ~flag_zero;
            3'b100:  pc_src = signed_lt;
            default: pc_src = ~signed_lt;
          endcase
        end
      end
      JAL, JALR: begin
        weReg     = 1'b1;
        sinalMux2 = 2'b10;
        sinalMux4 = (state == JALR);
        pc_src    = 1'b1;
        wePC      = 1'b1;
      end
      AUIPC: begin
        weReg     = 1'b1;
        sinalMux2 = 2'b11;
        wePC      = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: halted = 1'b0;
    endcase
    if (reset) begin
      weIR      = 1'b0;
      wePC      = 1'b0;
      weReg     = 1'b0;
      weMem     = 1'b0;
      sinalMux1 = 1'b0;
      sinalMux2 = 2'b00;
      sinalMux4 = 1'b0;
      pc_src    = 1'b0;
      control   = ALU_ADD;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     retired <= 32'd0;
    else if (wePC) retired <= retired + 32'd1;
  end

endmodule
